// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-memory I/O bridge: register offsets inside
// the I/O window and bit positions of the STATUS register.
package dmem_io_pkg;

    // Register offsets (cpu_addr[7:0]) inside the I/O window
    localparam logic [7:0] IO_LED    = 8'h00;
    localparam logic [7:0] IO_TX     = 8'h01;
    localparam logic [7:0] IO_STAT   = 8'h02;
    localparam logic [7:0] IO_CYC_LO = 8'h03;
    localparam logic [7:0] IO_CYC_HI = 8'h04;

    // STATUS register bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;

    // Width of the count field reported in STATUS
    localparam int ST_CNT_W   = 5;

endpackage

// File: rtl/dmem_io_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is only
// taken when a pop happens in the same cycle; otherwise it is reported on
// drop_o and discarded. head_o reads zero while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

    // A pop frees a slot, so a full FIFO can still take a push that cycle
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign drop_o  = push_i & full_o & ~w_pop;

    // Storage array: written on accepted pushes only
    // NOTE: the data array has no reset; validity is tracked by the count and pointers, so resetting it would only add a reset fan-out to every storage bit.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-memory bridge: passes CPU loads/stores to the data RAM and decodes a
// 256-word window at IO_BASE into LED, TX byte FIFO, STATUS and a free-running
// cycle counter whose high half is snapshotted when the low half is read.
module dmem_io_bridge
    import dmem_io_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = 16'hFF00,
    parameter int          TX_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic        cpu_we_i,
    output logic [15:0] cpu_rdata_o,
    output logic [15:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    output logic        ram_we_o,
    input  logic [15:0] ram_rdata_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [15:0] led_o
);

    localparam int CNT_W = $clog2(TX_DEPTH + 1);

    logic [15:0]      r_led;
    logic             r_ovf;
    logic [31:0]      r_cyc;
    logic [15:0]      r_snap_hi;

    logic             w_io_hit;
    logic [7:0]       w_off;
    logic             w_io_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [CNT_W-1:0] w_count;
    logic [15:0]      w_status;

    assign w_io_hit    = (cpu_addr_i[15:8] == IO_BASE[15:8]);
    assign w_off       = cpu_addr_i[7:0];
    assign w_io_wr     = w_io_hit & cpu_we_i;

    // RAM never sees a write that lands inside the I/O window
    assign ram_addr_o  = cpu_addr_i;
    assign ram_wdata_o = cpu_wdata_i;
    assign ram_we_o    = cpu_we_i & ~w_io_hit;

    assign w_push      = w_io_wr & (w_off == IO_TX);
    assign w_pop       = tx_valid_o & tx_ready_i;
    assign tx_valid_o  = ~w_empty;
    assign led_o       = r_led;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (cpu_wdata_i[7:0]),
        .pop_i   (w_pop),
        .head_o  (tx_data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .drop_o  (w_drop)
    );

    // Assemble the STATUS word from FIFO state and the sticky overflow flag
    always_comb begin
        w_status                            = '0;
        w_status[ST_EMPTY]                  = w_empty;
        w_status[ST_FULL]                   = w_full;
        w_status[ST_OVF]                    = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_count);
    end

    // Load data mux: RAM outside the window, mapped registers inside
    // NOTE: the output gets a default before the case so unmapped offsets cannot infer a latch.
    always_comb begin
        cpu_rdata_o = 16'h0000;
        if (!w_io_hit) begin
            cpu_rdata_o = ram_rdata_i;
        end else begin
            case (w_off)
                IO_LED:    cpu_rdata_o = r_led;
                IO_STAT:   cpu_rdata_o = w_status;
                IO_CYC_LO: cpu_rdata_o = r_cyc[15:0];
                IO_CYC_HI: cpu_rdata_o = r_snap_hi;
                default:   cpu_rdata_o = 16'h0000;
            endcase
        end
    end

    // LED register: full 16-bit write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= '0;
        end else if (w_io_wr && (w_off == IO_LED)) begin
            r_led <= cpu_wdata_i;
        end
    end

    // Sticky overflow: a dropped push beats a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_io_wr && (w_off == IO_STAT) && cpu_wdata_i[ST_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    // Free-running cycle counter; reading CYC_LO freezes the high half for CYC_HI
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cyc     <= '0;
            r_snap_hi <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_io_hit && !cpu_we_i && (w_off == IO_CYC_LO)) begin
                r_snap_hi <= r_cyc[31:16];
            end
        end
    end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Directed bench for dmem_io_bridge. A queue scoreboard holds the TX bytes the
// bench expects to drain; a small RAM model answers pass-through loads.
module tb_dmem_io_bridge;

    localparam int TX_DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] cpu_addr_i = '0;
    logic [15:0] cpu_wdata_i = '0;
    logic        cpu_we_i = 1'b0;
    logic [15:0] cpu_rdata_o;
    logic [15:0] ram_addr_o;
    logic [15:0] ram_wdata_o;
    logic        ram_we_o;
    logic [15:0] ram_rdata_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [15:0] led_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  sb[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc;
    logic [15:0] ram [256];

    dmem_io_bridge #(
        .IO_BASE  (16'hFF00),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_rdata_o (cpu_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_we_o    (ram_we_o),
        .ram_rdata_i (ram_rdata_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .led_o       (led_o)
    );

    always #5 clk_i = ~clk_i;

    // Data RAM model: combinational read, write on the clock edge
    assign ram_rdata_i = ram[ram_addr_o[7:0]];
    always @(posedge clk_i) begin
        if (ram_we_o) ram[ram_addr_o[7:0]] <= ram_wdata_o;
    end

    // Reference cycle count: cycles elapsed since reset release
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m_cyc <= '0;
        else         m_cyc <= m_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] status_exp();
        int n = sb.size();
        return {8'h00, 5'(n), m_ovf, (n == TX_DEPTH), (n == 0)};
    endfunction

    // One bus cycle: drive at the falling edge, check settled outputs,
    // update the scoreboard, then advance to the next falling edge.
    task automatic step(input logic [15:0] a, input logic [15:0] wd, input logic we,
                        input bit do_chk, input logic [15:0] exp_rd, input string tag);
        int  n0;
        bit  pop_now;
        cpu_addr_i  = a;
        cpu_wdata_i = wd;
        cpu_we_i    = we;
        #1;
        n0 = sb.size();
        chk({tag, ":ram_we"}, ram_we_o, we && (a[15:8] != 8'hFF));
        chk({tag, ":ram_addr"}, ram_addr_o, a);
        if (do_chk) chk({tag, ":rdata"}, cpu_rdata_o, exp_rd);
        chk({tag, ":tx_valid"}, tx_valid_o, n0 != 0);
        if (n0 == 0) chk({tag, ":tx_data_empty"}, tx_data_o, 8'h00);
        pop_now = tx_ready_i && (n0 != 0);
        if (pop_now) begin
            chk({tag, ":tx_data"}, tx_data_o, sb[0]);
            void'(sb.pop_front());
        end
        if (we && a == 16'hFF02 && wd[2]) m_ovf = 1'b0;
        if (we && a == 16'hFF01) begin
            if (n0 < TX_DEPTH || pop_now) sb.push_back(wd[7:0]);
            else                         m_ovf = 1'b1;
        end
        @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst:led", led_o, 16'h0000);
        chk("rst:tx_valid", tx_valid_o, 1'b0);
        chk("rst:tx_data", tx_data_o, 8'h00);
        #10 rst_ni = 1'b1;
        @(negedge clk_i);

        // Pass-through and LED
        step(16'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000, "st_ram");
        step(16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, "ld_ram");
        step(16'hFF00, 16'hBEEF, 1'b1, 1'b0, 16'h0000, "st_led");
        chk("led_after_write", led_o, 16'hBEEF);
        step(16'hFF00, 16'h0000, 1'b0, 1'b1, 16'hBEEF, "ld_led");
        step(16'hFF10, 16'h1234, 1'b1, 1'b0, 16'h0000, "st_unmapped");
        step(16'hFF10, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld_unmapped");
        step(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld_txdata");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_reset");

        // FIFO fill with consumer stalled, then one overflowing push
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++)
            step(16'hFF01, 16'h0041 + 16'(i), 1'b1, 1'b0, 16'h0000, "fill");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0042, "stat_full");
        step(16'hFF01, 16'h0049, 1'b1, 1'b0, 16'h0000, "push_ovf");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0046, "stat_ovf");

        // Drain on consecutive cycles; ovf stays sticky until cleared
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++)
            step(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "drain");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0005, "stat_drained");
        step(16'hFF02, 16'h0004, 1'b1, 1'b0, 16'h0000, "clr_ovf");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_cleared");

        // Push into a full FIFO while it pops: accepted, no overflow
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++)
            step(16'hFF01, 16'h0050 + 16'(i), 1'b1, 1'b0, 16'h0000, "refill");
        tx_ready_i = 1'b1;
        step(16'hFF01, 16'h005A, 1'b1, 1'b0, 16'h0000, "push_pop_full");
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, status_exp(), "stat_pp_full");
        for (int i = 0; i < 16 && sb.size() != 0; i++)
            step(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "drain_pp");
        chk("pp_drained", sb.size(), 0);
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_pp_done");

        // Cycle counter against the reference count
        step(16'hFF03, 16'h0000, 1'b0, 1'b1, m_cyc[15:0], "cyc_lo_a");
        for (int i = 0; i < 5; i++)
            step(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "cyc_idle");
        step(16'hFF03, 16'h0000, 1'b0, 1'b1, m_cyc[15:0], "cyc_lo_b");
        step(16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0000, "cyc_hi_small");

        // Snapshot across a low-half carry
        force dut.r_cyc = 32'h0001FFFF;
        step(16'hFF03, 16'h0000, 1'b0, 1'b1, 16'hFFFF, "snap_lo");
        release dut.r_cyc;
        step(16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0001, "snap_hi");

        // Asynchronous reset with bytes queued
        tx_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            step(16'hFF01, 16'h0061 + 16'(i), 1'b1, 1'b0, 16'h0000, "pre_rst");
        chk("pre_rst:led", led_o, 16'hBEEF);
        cpu_addr_i = 16'hFF02;
        cpu_we_i   = 1'b0;
        #1;
        chk("pre_rst:stat", cpu_rdata_o, status_exp());
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst:tx_valid", tx_valid_o, 1'b0);
        chk("async_rst:led", led_o, 16'h0000);
        chk("async_rst:count", cpu_rdata_o[7:3], 5'd0);
        sb.delete();
        m_ovf = 1'b0;
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        step(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0001, "stat_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_io_bridge.md
Name: dmem_io_bridge

Overview:
- Sits between the processor data-memory port and the data block_ram.
- Passes normal loads and stores through to RAM.
- Decodes a 256-word I/O window into memory-mapped registers: LED output, TX byte FIFO with valid/ready drain, and a 32-bit cycle counter with atomic snapshot.
- Lets test programs emit characters and measure cycle counts without changing the processor.

Parameters:
- IO_BASE, 16'hFF00, base address of I/O window; upper 8 bits are decoded, window is IO_BASE..IO_BASE+8'hFF.
- TX_DEPTH, 8, TX FIFO entries; must be a power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cpu_addr_i  in  16  processor data address.
- cpu_wdata_i  in  16  processor store data.
- cpu_we_i  in  1  processor store enable.
- cpu_rdata_o  out  16  load data to processor.
- ram_addr_o  out  16  address to data RAM.
- ram_wdata_o  out  16  store data to data RAM.
- ram_we_o  out  1  data RAM write enable.
- ram_rdata_i  in  16  data RAM read data.
- tx_data_o  out  8  FIFO head byte.
- tx_valid_o  out  1  FIFO non-empty.
- tx_ready_i  in  1  consumer accepts head byte.
- led_o  out  16  LED register.

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- io_hit = (cpu_addr_i[15:8] == IO_BASE[15:8]).
- Pass-through paths:
  - ram_addr_o = cpu_addr_i and ram_wdata_o = cpu_wdata_i, combinational.
  - ram_we_o = cpu_we_i & ~io_hit. RAM is never written inside the window.
- cpu_rdata_o is combinational: ram_rdata_i when ~io_hit, else the register selected by cpu_addr_i[7:0]. Unmapped offsets read 16'h0000 and ignore writes.
- Register map (offsets):
  - 0x00 LED: R/W, full 16 bits.
  - 0x01 TX_DATA: write pushes cpu_wdata_i[7:0]; reads 0.
  - 0x02 STATUS: read returns {8'b0, count[4:0] zero-extended into [7:3], ovf[2], full[1], empty[0]}. A write with bit2=1 clears ovf.
  - 0x03 CYC_LO: read returns counter[15:0]. Any cycle with addr=CYC_LO and cpu_we_i=0 latches counter[31:16] into snap_hi at the clock edge.
  - 0x04 CYC_HI: read returns snap_hi.
- Cycle counter: 32 bits, increments every cycle from reset, wraps 32'hFFFFFFFF→0.
- TX FIFO:
  - push = io_hit & cpu_we_i & offset==0x01.
  - pop = tx_valid_o & tx_ready_i.
  - tx_valid_o = ~empty. tx_data_o = head byte, 8'h00 when empty.
  - Push accepted when ~full, or when full with a pop in the same cycle. Occupancy stays full and the new byte is enqueued.
  - Push while full with no pop: byte dropped, ovf set (sticky).
  - Simultaneous push and pop when empty: push accepted, pop impossible (tx_valid_o=0).
  - Simultaneous push and pop otherwise: count unchanged, pointers both advance and wrap modulo TX_DEPTH.
  - count ranges 0..TX_DEPTH.
  - Ovf-clear write and overflow event in the same cycle: set wins.
- Reset values: led_o=0, FIFO empty, pointers 0, tx_valid_o=0, tx_data_o=0, ovf=0, counter=0, snap_hi=0.
- Reset mid-transfer: FIFO contents discarded, tx_valid_o drops immediately (asynchronous).
- Latency: register writes visible on the next cycle. FIFO push is visible on tx_valid_o the cycle after the write.

Decomposition:
- Package dmem_io_pkg: offset constants (IO_LED=8'h00, IO_TX=8'h01, IO_STAT=8'h02, IO_CYC_LO=8'h03, IO_CYC_HI=8'h04) and STATUS bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=3).
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, async active-low reset. The bridge instantiates it with WIDTH=8, DEPTH=TX_DEPTH.

Test Plan:
- Pass-through: store 16'hBEEF to 0x0010, then load 0x0010 → ram_we_o=1 on store, cpu_rdata_o=16'hBEEF. Store to 0xFF00 → ram_we_o=0, led_o=16'hBEEF next cycle.
- FIFO fill: tx_ready_i=0, write 0x41..0x48 to 0xFF01 → STATUS=16'h0042 (count 8, full). Ninth write 0x49 → STATUS bit2=1, count stays 8.
- Drain: tx_ready_i=1 → tx_data_o sequence 0x41..0x48 on 8 consecutive cycles, then tx_valid_o=0, STATUS=16'h0005 (empty, ovf still set). Write 16'h0004 to 0xFF02 → STATUS=16'h0001.
- Full + simultaneous push/pop: FIFO full, tx_ready_i=1, write 0x5A → accepted, ovf stays 0, 0x5A emerges last.
- Cycle snapshot: force counter to 32'h0001FFFF, read 0xFF03 → 16'hFFFF. Next cycle read 0xFF04 → 16'h0001, not 16'h0002.
- Async reset: assert rst_ni low mid-cycle with FIFO holding 3 bytes → tx_valid_o, led_o, STATUS.count go 0 without a clock edge. After release, STATUS=16'h0001.
